vga_text_console_ctrl: RTL and testbench
========================================

Name: vga_text_console_ctrl

Overview:
Terminal-style write sequencer that sits in front of vga_adapter's character-RAM write port (address / char_input / write_enable).
- Accepts a stream of 7-bit ASCII characters over a valid/ready handshake.
- Tracks a cursor and interprets control codes (CR, LF, BS, FF).
- Issues single-cycle RAM writes; runs clear-screen and clear-line fill sequences.
- Lets the host stop computing addresses itself.

Parameters:
COLS, 40, characters per row
ROWS, 30, rows per screen (COLS*ROWS must be <= 2**ADDR_W)
ADDR_W, 11, character RAM address width
CHAR_W, 7, character code width

Ports:
clk_20_mhz  input  1  system clock (20 MHz PLL output)
reset  input  1  asynchronous, active-high reset
in_char  input  CHAR_W  character / control code from host
in_valid  input  1  in_char is valid
in_ready  output  1  controller accepts in_char this cycle
wr_address  output  ADDR_W  to vga_adapter address
wr_char  output  CHAR_W  to vga_adapter char_input
wr_enable  output  1  to vga_adapter write_enable, one-cycle pulse per cell
cursor_col  output  clog2(COLS)  current cursor column
cursor_row  output  clog2(ROWS)  current cursor row
busy  output  1  high while a fill sequence is running

Behaviour:
- Single clock domain, clk_20_mhz; reset is asynchronous and active-high.
- Reset values: wr_enable=0, wr_address=0, wr_char=0, cursor_col=0, cursor_row=0, in_ready=0, busy=1.
- After reset the state is CLR_SCREEN with fill counter 0, so a power-up clear runs automatically.
- States: IDLE, CLR_SCREEN, CLR_LINE.
- in_ready = (state==IDLE); it is registered-state derived and has no combinational path from in_valid.
- A character is accepted when in_valid && in_ready on a rising edge.
- All write outputs are registered: acceptance in cycle N gives the wr_enable pulse in cycle N+1.
- Address = row_base + cursor_col.
  - row_base is kept as a register (cursor_row*COLS), updated by +COLS, or reset to 0 on row wrap.
  - No multiplier.
- Printable 0x20..0x7E:
  - Write in_char at the cursor, then cursor_col+1; state stays IDLE, so back-to-back throughput is 1 char/cycle.
  - If cursor_col was COLS-1: col=0, row advances (see row advance).
- 0x0D CR: col=0; no write.
- 0x0A LF: col=0, row advances.
- 0x08 BS:
  - If col>0: col-1 and write 0x20 at the new position.
  - If col==0: no-op, no write; row is not decremented.
- 0x0C FF: cursor to (0,0), enter CLR_SCREEN.
- Any other code: consumed, no write, no cursor change.
- Row advance: row+1, or 0 if row was ROWS-1 (wrap, no scrolling). Then enter CLR_LINE for the new row.
- CLR_SCREEN:
  - Writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle, ascending.
  - Back to IDLE the cycle after the last write.
  - Cursor stays (0,0).
- CLR_LINE:
  - Writes 0x20 to row_base..row_base+COLS-1, one per cycle: COLS consecutive pulses.
  - Back to IDLE the cycle after the last write.
- busy=1 in CLR_SCREEN/CLR_LINE; in_ready=0 there. Input is held by the host, never dropped.
- Reset asserted mid-fill: outputs return to reset values immediately; after release the full-screen clear restarts from address 0.
- wr_address never exceeds COLS*ROWS-1.

Decomposition:
- Package vga_text_pkg: ASCII constants (SPACE=0x20, CR, LF, BS, FF, PRINT_MIN=0x20, PRINT_MAX=0x7E) and the state enum.
- Sub-module vga_fill_engine:
  - Inputs: start address, count, start pulse.
  - Outputs: per-cycle address/write of SPACE, done pulse.
  - Shared by CLR_SCREEN and CLR_LINE.
- Top-level FSM, cursor and row_base logic live in vga_text_console_ctrl.

Test Plan:
- Reset release: busy=1, exactly 1200 wr_enable pulses at addresses 0..1199, all with wr_char=0x20. in_ready rises the cycle after address 1199.
- After clear, send "AB" back-to-back: wr_enable at addr 0 char 0x41, next cycle addr 1 char 0x42; cursor=(2,0).
- Send 40 printables on row 0:
  - Last write at addr 39, then cursor=(0,1).
  - 40 SPACE writes at addr 40..79 (CLR_LINE), with in_ready=0 throughout.
- At (5,3), send BS then CR:
  - BS writes 0x20 at addr 124; cursor=(4,3).
  - CR gives no write and cursor=(0,3).
- At row 29, send LF: cursor=(0,0), CLR_LINE writes addr 0..39.
- Mid CLR_SCREEN at address 600: assert reset. wr_enable=0 immediately; after release the clear restarts at address 0. Send 0x0C: full clear, cursor=(0,0).

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared ASCII codes and controller state encoding for the VGA text console.
// Imported by the fill engine and the console controller.
package vga_text_pkg;

    localparam logic [6:0] SPACE     = 7'h20;
    localparam logic [6:0] CR        = 7'h0D;
    localparam logic [6:0] LF        = 7'h0A;
    localparam logic [6:0] BS        = 7'h08;
    localparam logic [6:0] FF        = 7'h0C;
    localparam logic [6:0] PRINT_MIN = 7'h20;
    localparam logic [6:0] PRINT_MAX = 7'h7E;

    typedef enum logic [1:0] {
        IDLE,
        CLR_SCREEN,
        CLR_LINE
    } state_t;

endpackage

// File: rtl/vga_text_console_ctrl_if.sv
// Host character stream: in_char/in_valid from host, in_ready back.
// master = host side, slave = console controller side.
interface vga_text_console_ctrl_if #(
    parameter int CHAR_W = 7
);
    logic [CHAR_W-1:0] in_char;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_char,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_char,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/vga_fill_engine.sv
// Writes SPACE to count consecutive cells from start_addr, one per cycle.
// Ports: start/start_addr/count in; wr_address/wr_char/wr_enable, done out.
module vga_fill_engine
    import vga_text_pkg::*;
#(
    parameter  int ADDR_W = 11,
    parameter  int CHAR_W = 7,
    localparam int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] wr_address,
    output logic [CHAR_W-1:0] wr_char,
    output logic              wr_enable,
    output logic              done
);

    logic              active;
    logic [ADDR_W-1:0] cur;
    logic [CNT_W-1:0]  left;

    // done is asserted alongside the last write pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active     <= 1'b0;
            cur        <= '0;
            left       <= '0;
            wr_address <= '0;
            wr_char    <= '0;
            wr_enable  <= 1'b0;
            done       <= 1'b0;
        end else begin
            wr_enable <= 1'b0;
            done      <= 1'b0;
            if (start) begin
                active <= (count != '0);
                cur    <= start_addr;
                left   <= count;
            end else if (active) begin
                wr_enable  <= 1'b1;
                wr_address <= cur;
                wr_char    <= CHAR_W'(SPACE);
                cur        <= cur + 1'b1;
                left       <= left - 1'b1;
                if (left == CNT_W'(1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_text_console_ctrl.sv
// Terminal-style write sequencer for the vga_adapter character RAM.
// Ports: host stream (if), wr_* RAM write port, cursor, busy.
module vga_text_console_ctrl
    import vga_text_pkg::*;
#(
    parameter  int COLS   = 40,
    parameter  int ROWS   = 30,
    parameter  int ADDR_W = 11,
    parameter  int CHAR_W = 7,
    localparam int COL_W  = $clog2(COLS),
    localparam int ROW_W  = $clog2(ROWS),
    localparam int CNT_W  = ADDR_W + 1
) (
    input  logic                    clk_20_mhz,
    input  logic                    reset,
    vga_text_console_ctrl_if.slave  host,
    output logic [ADDR_W-1:0]       wr_address,
    output logic [CHAR_W-1:0]       wr_char,
    output logic                    wr_enable,
    output logic [COL_W-1:0]        cursor_col,
    output logic [ROW_W-1:0]        cursor_row,
    output logic                    busy
);

    state_t            state;
    logic [ADDR_W-1:0] row_base;
    logic              char_we;
    logic [ADDR_W-1:0] char_addr;
    logic [CHAR_W-1:0] char_data;
    // kicks the power-up clear once reset releases
    logic              fill_go;

    logic              accept;
    logic              is_print;
    logic              col_last;
    logic              row_last;
    logic [ROW_W-1:0]  row_nx;
    logic [ADDR_W-1:0] rb_nx;
    logic [ADDR_W-1:0] cell_addr;

    logic              fill_start;
    logic [ADDR_W-1:0] fill_base;
    logic [CNT_W-1:0]  fill_count;
    logic [ADDR_W-1:0] fill_addr;
    logic [CHAR_W-1:0] fill_char;
    logic              fill_we;
    logic              fill_done;

    assign host.in_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign accept        = host.in_valid && (state == IDLE);

    assign is_print  = (host.in_char >= CHAR_W'(PRINT_MIN))
                    && (host.in_char <= CHAR_W'(PRINT_MAX));
    assign col_last  = (cursor_col == COL_W'(COLS - 1));
    assign row_last  = (cursor_row == ROW_W'(ROWS - 1));
    assign row_nx    = row_last ? '0 : cursor_row + 1'b1;
    assign rb_nx     = row_last ? '0 : row_base + ADDR_W'(COLS);
    assign cell_addr = row_base + ADDR_W'(cursor_col);

    // line clear targets the row the cursor is moving onto
    always_comb begin
        fill_start = fill_go;
        fill_base  = '0;
        fill_count = CNT_W'(COLS * ROWS);
        if (accept) begin
            if (host.in_char == CHAR_W'(FF)) begin
                fill_start = 1'b1;
            end else if ((host.in_char == CHAR_W'(LF))
                      || (is_print && col_last)) begin
                fill_start = 1'b1;
                fill_base  = rb_nx;
                fill_count = CNT_W'(COLS);
            end
        end
    end

    always_ff @(posedge clk_20_mhz or posedge reset) begin
        if (reset) begin
            state      <= CLR_SCREEN;
            cursor_col <= '0;
            cursor_row <= '0;
            row_base   <= '0;
            char_we    <= 1'b0;
            char_addr  <= '0;
            char_data  <= '0;
            fill_go    <= 1'b1;
        end else begin
            char_we <= 1'b0;
            fill_go <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unique case (1'b1)
                            is_print: begin
                                char_we   <= 1'b1;
                                char_addr <= cell_addr;
                                char_data <= host.in_char;
                                if (col_last) begin
                                    cursor_col <= '0;
                                    cursor_row <= row_nx;
                                    row_base   <= rb_nx;
                                    state      <= CLR_LINE;
                                end else begin
                                    cursor_col <= cursor_col + 1'b1;
                                end
                            end
                            (host.in_char == CHAR_W'(CR)): begin
                                cursor_col <= '0;
                            end
                            (host.in_char == CHAR_W'(LF)): begin
                                cursor_col <= '0;
                                cursor_row <= row_nx;
                                row_base   <= rb_nx;
                                state      <= CLR_LINE;
                            end
                            (host.in_char == CHAR_W'(BS)): begin
                                if (cursor_col != '0) begin
                                    cursor_col <= cursor_col - 1'b1;
                                    char_we    <= 1'b1;
                                    char_addr  <= cell_addr - 1'b1;
                                    char_data  <= CHAR_W'(SPACE);
                                end
                            end
                            (host.in_char == CHAR_W'(FF)): begin
                                cursor_col <= '0;
                                cursor_row <= '0;
                                row_base   <= '0;
                                state      <= CLR_SCREEN;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                CLR_SCREEN, CLR_LINE: begin
                    if (fill_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    vga_fill_engine #(
        .ADDR_W (ADDR_W),
        .CHAR_W (CHAR_W)
    ) u_fill (
        .clk        (clk_20_mhz),
        .rst        (reset),
        .start      (fill_start),
        .start_addr (fill_base),
        .count      (fill_count),
        .wr_address (fill_addr),
        .wr_char    (fill_char),
        .wr_enable  (fill_we),
        .done       (fill_done)
    );

    // both sources are registers and never overlap
    assign wr_enable  = fill_we | char_we;
    assign wr_address = fill_we ? fill_addr : char_addr;
    assign wr_char    = fill_we ? fill_char : char_data;

endmodule

// File: tb/tb_vga_text_console_ctrl.sv
// Directed self-checking bench for vga_text_console_ctrl.
// Drives and samples on the falling edge of the 20 MHz clock.
module tb_vga_text_console_ctrl;

    logic        clk;
    logic        reset;
    logic [10:0] wr_address;
    logic [6:0]  wr_char;
    logic        wr_enable;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int vectors;
    int miscompares;

    vga_text_console_ctrl_if #(.CHAR_W(7)) host ();

    vga_text_console_ctrl dut (
        .clk_20_mhz (clk),
        .reset      (reset),
        .host       (host),
        .wr_address (wr_address),
        .wr_char    (wr_char),
        .wr_enable  (wr_enable),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    initial begin
        #(50 * 60000);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // consume one fill sequence: n consecutive SPACE writes from base
    task automatic expect_fill(input int base, input int n, input string nm);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < n && cyc < n + 20) begin
            @(negedge clk);
            cyc++;
            vectors++;
            if (host.in_ready !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s ready/busy: got %b/%b want 0/1",
                         nm, host.in_ready, busy);
            end
            if (got > 0 && wr_enable !== 1'b1) begin
                miscompares++;
                $display("FAIL %s gap: got we=%b want 1 at %0d", nm, wr_enable, got);
            end
            if (wr_enable === 1'b1) begin
                vectors++;
                if (wr_address !== 11'(base + got) || wr_char !== 7'h20) begin
                    miscompares++;
                    $display("FAIL %s write: got %0d/%h want %0d/20",
                             nm, wr_address, wr_char, base + got);
                end
                got++;
            end
        end
        vectors++;
        if (got != n) begin
            miscompares++;
            $display("FAIL %s count: got %0d want %0d", nm, got, n);
        end
        @(negedge clk);
        vectors++;
        if (host.in_ready !== 1'b1 || busy !== 1'b0 || wr_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL %s end: got rdy=%b busy=%b we=%b want 1 0 0",
                     nm, host.in_ready, busy, wr_enable);
        end
    endtask

    // returns on the falling edge after acceptance
    task automatic send_one(input logic [6:0] c);
        int w;
        w = 0;
        while (host.in_ready !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        host.in_char  = c;
        host.in_valid = 1'b1;
        @(negedge clk);
        host.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        host.in_valid = 1'b0;
        host.in_char  = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (wr_enable !== 1'b0 || wr_address !== 11'd0 || wr_char !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_wr: got %b %0d %h want 0 0 0",
                     wr_enable, wr_address, wr_char);
        end
        vectors++;
        if (cursor_col !== 6'd0 || cursor_row !== 5'd0
            || host.in_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: got col=%0d row=%0d rdy=%b busy=%b want 0 0 0 1",
                     cursor_col, cursor_row, host.in_ready, busy);
        end
        reset = 1'b0;
        expect_fill(0, 1200, "powerup_clear");
    endtask

    task automatic test_back_to_back();
        host.in_char  = 7'h41;
        host.in_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (wr_enable !== 1'b1 || wr_address !== 11'd0 || wr_char !== 7'h41) begin
            miscompares++;
            $display("FAIL b2b_A: got %b %0d %h want 1 0 41",
                     wr_enable, wr_address, wr_char);
        end
        host.in_char = 7'h42;
        @(negedge clk);
        host.in_valid = 1'b0;
        vectors++;
        if (wr_enable !== 1'b1 || wr_address !== 11'd1 || wr_char !== 7'h42) begin
            miscompares++;
            $display("FAIL b2b_B: got %b %0d %h want 1 1 42",
                     wr_enable, wr_address, wr_char);
        end
        vectors++;
        if (cursor_col !== 6'd2 || cursor_row !== 5'd0) begin
            miscompares++;
            $display("FAIL b2b_cursor: got (%0d,%0d) want (2,0)", cursor_col, cursor_row);
        end
    endtask

    task automatic test_line_wrap();
        logic [6:0] c;
        send_one(7'h0D);
        vectors++;
        if (wr_enable !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            miscompares++;
            $display("FAIL wrap_cr: got we=%b (%0d,%0d) want 0 (0,0)",
                     wr_enable, cursor_col, cursor_row);
        end
        host.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            c = 7'h61 + 7'(i % 26);
            host.in_char = c;
            @(negedge clk);
            vectors++;
            if (wr_enable !== 1'b1 || wr_address !== 11'(i) || wr_char !== c) begin
                miscompares++;
                $display("FAIL wrap_char: got %b %0d %h want 1 %0d %h",
                         wr_enable, wr_address, wr_char, i, c);
            end
        end
        host.in_valid = 1'b0;
        vectors++;
        if (cursor_col !== 6'd0 || cursor_row !== 5'd1 || host.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_cursor: got (%0d,%0d) rdy=%b want (0,1) 0",
                     cursor_col, cursor_row, host.in_ready);
        end
        expect_fill(40, 40, "wrap_clr_line");
    endtask

    task automatic test_bs_cr();
        logic [6:0] txt [5];
        txt = '{7'h68, 7'h65, 7'h6C, 7'h6C, 7'h6F};
        send_one(7'h0A);
        expect_fill(80, 40, "lf_row2");
        send_one(7'h0A);
        expect_fill(120, 40, "lf_row3");
        for (int i = 0; i < 5; i++) begin
            send_one(txt[i]);
            vectors++;
            if (wr_enable !== 1'b1 || wr_address !== 11'(120 + i) || wr_char !== txt[i]) begin
                miscompares++;
                $display("FAIL row3_char: got %b %0d %h want 1 %0d %h",
                         wr_enable, wr_address, wr_char, 120 + i, txt[i]);
            end
        end
        send_one(7'h08);
        vectors++;
        if (wr_enable !== 1'b1 || wr_address !== 11'd124 || wr_char !== 7'h20) begin
            miscompares++;
            $display("FAIL bs_write: got %b %0d %h want 1 124 20",
                     wr_enable, wr_address, wr_char);
        end
        vectors++;
        if (cursor_col !== 6'd4 || cursor_row !== 5'd3) begin
            miscompares++;
            $display("FAIL bs_cursor: got (%0d,%0d) want (4,3)", cursor_col, cursor_row);
        end
        send_one(7'h0D);
        vectors++;
        if (wr_enable !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 5'd3) begin
            miscompares++;
            $display("FAIL cr: got we=%b (%0d,%0d) want 0 (0,3)",
                     wr_enable, cursor_col, cursor_row);
        end
    endtask

    task automatic test_last_row_lf();
        for (int r = 3; r < 29; r++) begin
            send_one(7'h0A);
            expect_fill((r + 1) * 40, 40, "lf_walk");
        end
        vectors++;
        if (cursor_col !== 6'd0 || cursor_row !== 5'd29) begin
            miscompares++;
            $display("FAIL row29: got (%0d,%0d) want (0,29)", cursor_col, cursor_row);
        end
        send_one(7'h0A);
        vectors++;
        if (cursor_col !== 6'd0 || cursor_row !== 5'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL row_wrap: got (%0d,%0d) busy=%b want (0,0) 1",
                     cursor_col, cursor_row, busy);
        end
        expect_fill(0, 40, "row_wrap_clr");
    endtask

    task automatic test_ignored();
        send_one(7'h01);
        vectors++;
        if (wr_enable !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 5'd0
            || host.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL other_code: got we=%b (%0d,%0d) rdy=%b want 0 (0,0) 1",
                     wr_enable, cursor_col, cursor_row, host.in_ready);
        end
        send_one(7'h08);
        vectors++;
        if (wr_enable !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            miscompares++;
            $display("FAIL bs_col0: got we=%b (%0d,%0d) want 0 (0,0)",
                     wr_enable, cursor_col, cursor_row);
        end
    endtask

    task automatic test_reset_mid_fill();
        int w;
        send_one(7'h0C);
        w = 0;
        while (!(wr_enable === 1'b1 && wr_address === 11'd600) && w < 700) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (w >= 700) begin
            miscompares++;
            $display("FAIL mid_reach: got timeout want addr 600");
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (wr_enable !== 1'b0 || wr_address !== 11'd0 || wr_char !== 7'd0
            || busy !== 1'b1 || host.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got we=%b a=%0d c=%h busy=%b rdy=%b want 0 0 0 1 0",
                     wr_enable, wr_address, wr_char, busy, host.in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        expect_fill(0, 1200, "restart_clear");
    endtask

    task automatic test_form_feed();
        send_one(7'h5A);
        vectors++;
        if (wr_enable !== 1'b1 || wr_address !== 11'd0 || cursor_col !== 6'd1) begin
            miscompares++;
            $display("FAIL ff_pre: got we=%b a=%0d col=%0d want 1 0 1",
                     wr_enable, wr_address, cursor_col);
        end
        send_one(7'h0C);
        vectors++;
        if (wr_enable !== 1'b0 || cursor_col !== 6'd0 || cursor_row !== 5'd0
            || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ff_start: got we=%b (%0d,%0d) busy=%b want 0 (0,0) 1",
                     wr_enable, cursor_col, cursor_row, busy);
        end
        expect_fill(0, 1200, "ff_clear");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_back_to_back();
        test_line_wrap();
        test_bs_cr();
        test_last_row_lf();
        test_ignored();
        test_reset_mid_fill();
        test_form_feed();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
